idu_stage: RTL
==============

# idu_stage

Parametrised, pipelined instruction-decode stage for the NPC core. Accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into a one-hot type vector and a sign-extended immediate. Reads two operands from an internal register file, gated by a per-register busy scoreboard, and registers the result for the execute stage. Sits between IFU and EXU, replacing the single-cycle combinational decoder plus GPR pairing.

## Interface
Parameters:
- XLEN, 32, datapath and PC width.
- NREG, 32, architectural registers: 32 for RV32I, 16 for RV32E. Index width is RW = $clog2(NREG).
- TYPE_W, 64, width of the one-hot instruction-type vector.

Ports (one clock; reset is synchronous and active-high, ports `clk` and `rst`):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IFU offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts the bundle
- out_pc  out  XLEN  registered PC
- out_inst_type  out  TYPE_W  one-hot type; all zero when illegal
- out_imm  out  XLEN  sign- or zero-extended immediate; 0 for R-type and illegal
- out_rd  out  5  destination index
- out_rd_wen  out  1  instruction writes rd, and rd != 0
- out_rdata1  out  XLEN  operand 1
- out_rdata2  out  XLEN  operand 2
- out_shamt  out  5  inst[24:20]
- out_illegal  out  1  undecodable encoding
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback index
- wb_data  in  XLEN  writeback data
- flush  in  1  discard the held bundle

## Operation
- Decode covers full RV32I: lui, auipc, jal, jalr, all branches, lb/lh/lw/lbu/lhu, sb/sh/sw, all OP-IMM, all OP, ecall, ebreak.
  - Each instruction maps to one fixed bit of out_inst_type. Bit assignments are listed in the package.
- Immediate formats:
  - I-type: sign-extended inst[31:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
  - B-type: sign-extended 13-bit value, LSB 0.
  - J-type: sign-extended 21-bit value, LSB 0.
  - U-type: {inst[31:12], 12'b0}.
- Illegal cases, each giving out_illegal=1, type 0 and imm 0:
  - any unlisted encoding;
  - any used register index >= NREG (e.g. index 16–31 with NREG=16).
- Register file: NREG×XLEN, synchronous write on wb_en. x0 reads 0 and ignores writes.
  - A read of wb_addr in the same cycle as the write returns wb_data (write-through bypass).
- Scoreboard: one busy bit per register.
  - Set on accept when out_rd_wen would be 1.
  - Cleared on wb_en for wb_addr.
  - Set and clear on the same index in the same cycle leaves the bit at 1.
- Hazard: any of rs1 (if used), rs2 (if used) or rd (if written) is busy and is not being cleared by wb this cycle. Covers RAW and WAW.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Flush: when flush && out_valid, out_valid drops to 0 next cycle.
  - The busy bit that the flushed bundle set is cleared.
  - No instruction is accepted in the flush cycle.

## Timing
- Latency: 1 cycle. A bundle accepted at edge N is visible with out_valid=1 after edge N.
- out_valid holds, and all out_* stay stable, until out_valid && out_ready.
- Back-to-back throughput is 1/cycle when there is no hazard.
- Reset values:
  - out_valid=0; all out_* data = 0; out_illegal=0.
  - All busy bits 0; all registers 0.
- Reset mid-operation discards the held bundle and all pending scoreboard state.
- in_ready is combinational from the inputs and state; it has no dependency on out_ready through registers.

## Configuration
- IDU_SCOREBOARD_EN defined: scoreboard and hazard stall behave as described above.
- IDU_SCOREBOARD_EN undefined: no busy bits, hazard is constant 0, in_ready = (!out_valid || out_ready) && !flush. Downstream forwarding is then responsible for correctness.

## Structure
- Shared package `idu_pkg` holds:
  - opcode/funct3/funct7 localparams;
  - inst-type bit-index constants, including the mapping from the legacy one-hot values: addi=bit0, jalr=bit1, ebreak=bit2, add=bit3, lui=bit4, …;
  - the immediate-format enum.
- One sub-module, `idu_regfile`: parametrised NREG×XLEN register file, two read ports, one write port, with write-through bypass.
- Decode logic stays combinational inside `idu_stage`; the output bundle register and the scoreboard are local.

## Test plan
- addi x1,x0,-5 (0xFFB00093) with out_ready=1 → one cycle later: addi bit set, out_imm=0xFFFFFFFB, out_rd=1, out_rd_wen=1, busy[1]=1.
- Next in_inst add x2,x1,x1 with no writeback → in_ready=0 (stall). Then wb_en=1, wb_addr=1, wb_data=7 → accepted that same cycle, out_rdata1=out_rdata2=7.
- out_ready=0 for 3 cycles with in_valid=1 → out_* stable, in_ready=0; release → next instruction accepted on the first ready cycle.
- beq offset -4 (0xFE000EE3) → beq bit set, out_imm=0xFFFFFFFC, out_rd_wen=0, no busy bit set.
- NREG=16: add x17,x1,x2 → out_illegal=1, out_inst_type=0; word 0xFFFFFFFF → out_illegal=1.
- flush while holding lw x5 → out_valid=0 next cycle, busy[5]=0. With IDU_SCOREBOARD_EN undefined, the stalling add sequence above is accepted without a stall.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared decode definitions for the IDU: opcodes, funct fields, one-hot
// instruction-type bit indices and the immediate-format enum.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Bits 0..4 keep the legacy one-hot positions.
  localparam logic [6:0] T_ADDI  = 7'd0,  T_JALR  = 7'd1,  T_EBREAK = 7'd2,  T_ADD  = 7'd3;
  localparam logic [6:0] T_LUI   = 7'd4,  T_AUIPC = 7'd5,  T_JAL    = 7'd6,  T_BEQ  = 7'd7;
  localparam logic [6:0] T_BNE   = 7'd8,  T_BLT   = 7'd9,  T_BGE    = 7'd10, T_BLTU = 7'd11;
  localparam logic [6:0] T_BGEU  = 7'd12, T_LB    = 7'd13, T_LH     = 7'd14, T_LW   = 7'd15;
  localparam logic [6:0] T_LBU   = 7'd16, T_LHU   = 7'd17, T_SB     = 7'd18, T_SH   = 7'd19;
  localparam logic [6:0] T_SW    = 7'd20, T_SLTI  = 7'd21, T_SLTIU  = 7'd22, T_XORI = 7'd23;
  localparam logic [6:0] T_ORI   = 7'd24, T_ANDI  = 7'd25, T_SLLI   = 7'd26, T_SRLI = 7'd27;
  localparam logic [6:0] T_SRAI  = 7'd28, T_SUB   = 7'd29, T_SLL    = 7'd30, T_SLT  = 7'd31;
  localparam logic [6:0] T_SLTU  = 7'd32, T_XOR   = 7'd33, T_SRL    = 7'd34, T_SRA  = 7'd35;
  localparam logic [6:0] T_OR    = 7'd36, T_AND   = 7'd37, T_ECALL  = 7'd38;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic       known;
    logic [6:0] bit_idx;
    imm_fmt_e   fmt;
    logic       use_rs1;
    logic       use_rs2;
    logic       writes_rd;
  } dec_t;

  function automatic dec_t mk(logic [6:0] idx, imm_fmt_e f, logic u1, logic u2, logic wr);
    return '{known: 1'b1, bit_idx: idx, fmt: f, use_rs1: u1, use_rs2: u2, writes_rd: wr};
  endfunction

  function automatic dec_t decode(logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    d  = '0;
    case (inst[6:0])
      OPC_LUI:   d = mk(T_LUI,   IMM_U, 1'b0, 1'b0, 1'b1);
      OPC_AUIPC: d = mk(T_AUIPC, IMM_U, 1'b0, 1'b0, 1'b1);
      OPC_JAL:   d = mk(T_JAL,   IMM_J, 1'b0, 1'b0, 1'b1);
      OPC_JALR:  if (f3 == 3'b000) d = mk(T_JALR, IMM_I, 1'b1, 1'b0, 1'b1);
      OPC_BRANCH:
        case (f3)
          F3_BEQ:  d = mk(T_BEQ,  IMM_B, 1'b1, 1'b1, 1'b0);
          F3_BNE:  d = mk(T_BNE,  IMM_B, 1'b1, 1'b1, 1'b0);
          F3_BLT:  d = mk(T_BLT,  IMM_B, 1'b1, 1'b1, 1'b0);
          F3_BGE:  d = mk(T_BGE,  IMM_B, 1'b1, 1'b1, 1'b0);
          F3_BLTU: d = mk(T_BLTU, IMM_B, 1'b1, 1'b1, 1'b0);
          F3_BGEU: d = mk(T_BGEU, IMM_B, 1'b1, 1'b1, 1'b0);
          default: ;
        endcase
      OPC_LOAD:
        case (f3)
          F3_B:    d = mk(T_LB,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_H:    d = mk(T_LH,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_W:    d = mk(T_LW,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_BU:   d = mk(T_LBU, IMM_I, 1'b1, 1'b0, 1'b1);
          F3_HU:   d = mk(T_LHU, IMM_I, 1'b1, 1'b0, 1'b1);
          default: ;
        endcase
      OPC_STORE:
        case (f3)
          F3_B:    d = mk(T_SB, IMM_S, 1'b1, 1'b1, 1'b0);
          F3_H:    d = mk(T_SH, IMM_S, 1'b1, 1'b1, 1'b0);
          F3_W:    d = mk(T_SW, IMM_S, 1'b1, 1'b1, 1'b0);
          default: ;
        endcase
      OPC_OPIMM:
        case (f3)
          F3_ADD:  d = mk(T_ADDI,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_SLT:  d = mk(T_SLTI,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_SLTU: d = mk(T_SLTIU, IMM_I, 1'b1, 1'b0, 1'b1);
          F3_XOR:  d = mk(T_XORI,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_OR:   d = mk(T_ORI,   IMM_I, 1'b1, 1'b0, 1'b1);
          F3_AND:  d = mk(T_ANDI,  IMM_I, 1'b1, 1'b0, 1'b1);
          F3_SLL:  if (f7 == F7_BASE) d = mk(T_SLLI, IMM_I, 1'b1, 1'b0, 1'b1);
          F3_SR:
            if (f7 == F7_BASE)     d = mk(T_SRLI, IMM_I, 1'b1, 1'b0, 1'b1);
            else if (f7 == F7_ALT) d = mk(T_SRAI, IMM_I, 1'b1, 1'b0, 1'b1);
          default: ;
        endcase
      OPC_OP:
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  d = mk(T_ADD,  IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_SLL:  d = mk(T_SLL,  IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_SLT:  d = mk(T_SLT,  IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_SLTU: d = mk(T_SLTU, IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_XOR:  d = mk(T_XOR,  IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_SR:   d = mk(T_SRL,  IMM_NONE, 1'b1, 1'b1, 1'b1);
            F3_OR:   d = mk(T_OR,   IMM_NONE, 1'b1, 1'b1, 1'b1);
            default: d = mk(T_AND,  IMM_NONE, 1'b1, 1'b1, 1'b1);
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == F3_ADD)     d = mk(T_SUB, IMM_NONE, 1'b1, 1'b1, 1'b1);
          else if (f3 == F3_SR) d = mk(T_SRA, IMM_NONE, 1'b1, 1'b1, 1'b1);
        end
      OPC_SYSTEM:
        if (inst == INST_ECALL)       d = mk(T_ECALL,  IMM_I, 1'b0, 1'b0, 1'b0);
        else if (inst == INST_EBREAK) d = mk(T_EBREAK, IMM_I, 1'b0, 1'b0, 1'b0);
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/idu_if.sv
// IFU->IDU request and IDU->EXU decoded bundle; slave is the decode stage.
interface idu_if #(
  parameter int XLEN   = 32,
  parameter int TYPE_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [TYPE_W-1:0] out_inst_type;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rd;
  logic              out_rd_wen;
  logic [XLEN-1:0]   out_rdata1;
  logic [XLEN-1:0]   out_rdata2;
  logic [4:0]        out_shamt;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_inst_type, out_imm, out_rd, out_rd_wen,
           out_rdata1, out_rdata2, out_shamt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_inst_type, out_imm, out_rd, out_rd_wen,
           out_rdata1, out_rdata2, out_shamt, out_illegal
  );
endinterface

// File: rtl/idu_regfile.sv
// NREG x XLEN register file, two read ports, one write port; x0 is hardwired
// to zero and a same-cycle write is forwarded to the read ports.
module idu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2
);
  logic [NREG-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst)                    regs <= '0;
    else if (wen && waddr != 0) regs[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (wen && waddr == raddr1) rdata1 = wdata;
    if (wen && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 0) rdata1 = '0;
    if (raddr2 == 0) rdata2 = '0;
  end
endmodule

// File: rtl/idu_stage.sv
// Pipelined RV32I decode stage with register read and output bundle register.
// Define IDU_SCOREBOARD_EN to enable the busy-bit scoreboard and hazard stall.
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int TYPE_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  idu_if.slave            bus,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);
  localparam int RW = $clog2(NREG);

  dec_t              dec;
  logic [31:0]       inst;
  logic [4:0]        rs1, rs2, rd;
  logic              legal, rd_wen, hazard, accept, wb_ok;
  logic [XLEN-1:0]   imm, rdata1, rdata2;
  logic [TYPE_W-1:0] type_vec;

  function automatic logic reg_ok(logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  assign inst  = bus.in_inst;
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign rd    = inst[11:7];
  assign dec   = decode(inst);
  assign legal = dec.known && !(dec.use_rs1 && !reg_ok(rs1)) &&
                 !(dec.use_rs2 && !reg_ok(rs2)) && !(dec.writes_rd && !reg_ok(rd));
  assign rd_wen   = legal && dec.writes_rd && rd != 5'd0;
  assign type_vec = legal ? (TYPE_W'(1'b1) << dec.bit_idx) : '0;
  assign wb_ok    = wb_en && reg_ok(wb_addr);

  always_comb begin
    imm = '0;
    case (dec.fmt)
      IMM_I:   imm = XLEN'($signed(inst[31:20]));
      IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
    if (!legal) imm = '0;
  end

  idu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wen    (wb_ok),
    .waddr  (wb_addr[RW-1:0]),
    .wdata  (wb_data),
    .raddr1 (rs1[RW-1:0]),
    .raddr2 (rs2[RW-1:0]),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

`ifdef IDU_SCOREBOARD_EN
  logic [NREG-1:0] busy, busy_live, busy_next;

  // A register being written back this cycle no longer blocks issue.
  always_comb begin
    busy_live = busy;
    if (wb_ok) busy_live[wb_addr[RW-1:0]] = 1'b0;
    busy_next = busy_live;
    if (flush && bus.out_valid && bus.out_rd_wen) busy_next[bus.out_rd[RW-1:0]] = 1'b0;
    if (accept && rd_wen) busy_next[rd[RW-1:0]] = 1'b1;
  end

  assign hazard = legal && ((dec.use_rs1   && busy_live[rs1[RW-1:0]]) ||
                            (dec.use_rs2   && busy_live[rs2[RW-1:0]]) ||
                            (dec.writes_rd && busy_live[rd[RW-1:0]]));

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end
`else
  assign hazard = 1'b0;
`endif

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_inst_type <= '0;
      bus.out_imm       <= '0;
      bus.out_rd        <= '0;
      bus.out_rd_wen    <= 1'b0;
      bus.out_rdata1    <= '0;
      bus.out_rdata2    <= '0;
      bus.out_shamt     <= '0;
      bus.out_illegal   <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= bus.in_pc;
      bus.out_inst_type <= type_vec;
      bus.out_imm       <= imm;
      bus.out_rd        <= rd;
      bus.out_rd_wen    <= rd_wen;
      bus.out_rdata1    <= rdata1;
      bus.out_rdata2    <= rdata2;
      bus.out_shamt     <= inst[24:20];
      bus.out_illegal   <= !legal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
